// File: rtl/palette_ram_arbiter.sv
// palette_ram_arbiter
//
// Shares the single-port palette RAM between the video colour path and the
// CPU palette bus. A video read always gets the RAM in its own cycle. A CPU
// access is latched and then issued in the first cycle without a video read.
// It completes with a four-phase request/acknowledge handshake.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   io_video_rd/addr     video palette read strobe and address
//   io_video_valid/dout  video read data, one cycle after the strobe
//   io_cpu_rd/wr         CPU read / write request levels (write wins if both)
//   io_cpu_addr/din/mask CPU word address, write data, byte enables
//   io_cpu_ack           CPU acknowledge level, held until the request drops
//   io_cpu_dout          CPU read data, registered
//   io_ram_*             palette RAM port (io_ram_dout valid 1 cycle after rd)
//   io_maxWait           largest CPU stall seen since reset, in cycles
module palette_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_video_rd,
  input  logic [ADDR_WIDTH-1:0] io_video_addr,
  output logic                  io_video_valid,
  output logic [DATA_WIDTH-1:0] io_video_dout,
  input  logic                  io_cpu_rd,
  input  logic                  io_cpu_wr,
  input  logic [ADDR_WIDTH-1:0] io_cpu_addr,
  input  logic [DATA_WIDTH-1:0] io_cpu_din,
  input  logic [1:0]            io_cpu_mask,
  output logic                  io_cpu_ack,
  output logic [DATA_WIDTH-1:0] io_cpu_dout,
  output logic                  io_ram_rd,
  output logic                  io_ram_wr,
  output logic [ADDR_WIDTH-1:0] io_ram_addr,
  output logic [DATA_WIDTH-1:0] io_ram_din,
  output logic [1:0]            io_ram_mask,
  input  logic [DATA_WIDTH-1:0] io_ram_dout,
  output logic [WAIT_WIDTH-1:0] io_maxWait
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    RDATA = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pend_addr_reg;
  logic [DATA_WIDTH-1:0] pend_din_reg;
  logic [1:0]            pend_mask_reg;
  logic                  pend_wr_reg;
  logic [WAIT_WIDTH-1:0] wait_cnt_reg;
  logic [WAIT_WIDTH-1:0] max_wait_reg;
  logic [DATA_WIDTH-1:0] cpu_dout_reg;
  logic                  video_valid_reg;

  // Decoded FSM controls
  logic latch_req;
  logic issue;
  logic stall;
  logic capture;
  logic cpu_ack;

  always_comb begin
    state_next = state_reg;
    latch_req  = 1'b0;
    issue      = 1'b0;
    stall      = 1'b0;
    capture    = 1'b0;
    cpu_ack    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (io_cpu_wr || io_cpu_rd) begin
          latch_req  = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        if (io_video_rd) begin
          stall = 1'b1;
        end else begin
          issue      = 1'b1;
          state_next = pend_wr_reg ? ACK : RDATA;
        end
      end
      RDATA: begin
        capture    = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        cpu_ack = 1'b1;
        if (!io_cpu_rd && !io_cpu_wr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM port mux. Video has absolute priority. The CPU access is gated by
  // reset so that an aborted pending write never reaches the RAM.
  always_comb begin
    io_ram_rd   = 1'b0;
    io_ram_wr   = 1'b0;
    io_ram_addr = pend_addr_reg;
    io_ram_din  = pend_din_reg;
    io_ram_mask = pend_mask_reg;
    if (io_video_rd) begin
      io_ram_rd   = 1'b1;
      io_ram_addr = io_video_addr;
    end else if (issue && !reset) begin
      io_ram_wr = pend_wr_reg;
      io_ram_rd = ~pend_wr_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      pend_addr_reg   <= '0;
      pend_din_reg    <= '0;
      pend_mask_reg   <= '0;
      pend_wr_reg     <= 1'b0;
      wait_cnt_reg    <= '0;
      max_wait_reg    <= '0;
      cpu_dout_reg    <= '0;
      video_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      video_valid_reg <= io_video_rd;
      if (latch_req) begin
        pend_addr_reg <= io_cpu_addr;
        pend_din_reg  <= io_cpu_din;
        pend_mask_reg <= io_cpu_mask;
        pend_wr_reg   <= io_cpu_wr;
        wait_cnt_reg  <= '0;
      end
      // Saturate rather than wrap so a very long stall still reads as max.
      if (stall && (wait_cnt_reg != {WAIT_WIDTH{1'b1}})) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (issue && (wait_cnt_reg > max_wait_reg)) begin
        max_wait_reg <= wait_cnt_reg;
      end
      if (capture) begin
        cpu_dout_reg <= io_ram_dout;
      end
    end
  end

  assign io_cpu_ack     = cpu_ack;
  assign io_cpu_dout    = cpu_dout_reg;
  assign io_video_valid = video_valid_reg;
  assign io_video_dout  = io_ram_dout;
  assign io_maxWait     = max_wait_reg;

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Testbench for palette_ram_arbiter: a behavioural RAM and a scoreboard.
// A reference model predicts the RAM activity, video data, CPU ack timing
// and read data, and the max-wait statistic.
module tb_palette_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int WW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_video_rd;
  logic [AW-1:0] io_video_addr;
  logic          io_video_valid;
  logic [DW-1:0] io_video_dout;
  logic          io_cpu_rd, io_cpu_wr;
  logic [AW-1:0] io_cpu_addr;
  logic [DW-1:0] io_cpu_din;
  logic [1:0]    io_cpu_mask;
  logic          io_cpu_ack;
  logic [DW-1:0] io_cpu_dout;
  logic          io_ram_rd, io_ram_wr;
  logic [AW-1:0] io_ram_addr;
  logic [DW-1:0] io_ram_din;
  logic [1:0]    io_ram_mask;
  logic [DW-1:0] io_ram_dout;
  logic [WW-1:0] io_maxWait;

  palette_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_WIDTH(WW)) dut (
    .clock(clock), .reset(reset),
    .io_video_rd(io_video_rd), .io_video_addr(io_video_addr),
    .io_video_valid(io_video_valid), .io_video_dout(io_video_dout),
    .io_cpu_rd(io_cpu_rd), .io_cpu_wr(io_cpu_wr), .io_cpu_addr(io_cpu_addr),
    .io_cpu_din(io_cpu_din), .io_cpu_mask(io_cpu_mask), .io_cpu_ack(io_cpu_ack),
    .io_cpu_dout(io_cpu_dout),
    .io_ram_rd(io_ram_rd), .io_ram_wr(io_ram_wr), .io_ram_addr(io_ram_addr),
    .io_ram_din(io_ram_din), .io_ram_mask(io_ram_mask), .io_ram_dout(io_ram_dout),
    .io_maxWait(io_maxWait)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural palette RAM ----------------
  logic [DW-1:0] mem [int];

  function automatic logic [DW-1:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  always @(posedge clock) begin
    logic [DW-1:0] w;
    if (io_ram_wr) begin
      w = mem_rd(int'(io_ram_addr));
      if (io_ram_mask[0]) w[7:0]  = io_ram_din[7:0];
      if (io_ram_mask[1]) w[15:8] = io_ram_din[15:8];
      mem[int'(io_ram_addr)] = w;
    end
    if (io_ram_rd) io_ram_dout <= mem_rd(int'(io_ram_addr));
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    mask;
    int            req_cyc;
  } xact_t;

  typedef struct {
    int            cyc;
    bit            rd;
    logic [DW-1:0] dout;
  } ack_t;

  logic [DW-1:0] ref_mem [int];
  xact_t         pend_q[$];
  ack_t          ack_q[$];
  logic [DW-1:0] vid_q[$];
  int            ref_maxwait = 0;
  bit            ack_prev = 1'b0;

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Monitor + model, evaluated mid-cycle on stable DUT outputs.
  always @(negedge clock) begin
    xact_t         x;
    ack_t          a;
    logic [DW-1:0] e;
    int            waited;
    if (reset) begin
      pend_q.delete();
      ack_q.delete();
      vid_q.delete();
      ref_maxwait = 0;
      ack_prev    = 1'b0;
    end else begin
      // video response
      if (io_video_valid) begin
        if (vid_q.size() == 0) fail_now("video_valid_unexpected");
        else begin
          e = vid_q.pop_front();
          chk("video_dout", io_video_dout, e);
        end
      end
      // CPU ack rising edge
      if (io_cpu_ack && !ack_prev) begin
        if (ack_q.size() == 0) fail_now("ack_unexpected");
        else begin
          a = ack_q.pop_front();
          chk("ack_cycle", cyc, a.cyc);
          if (a.rd) chk("cpu_dout", io_cpu_dout, a.dout);
        end
      end
      ack_prev = io_cpu_ack;
      // RAM port prediction
      if (io_video_rd) begin
        chk("video_ram_port", {io_ram_rd, io_ram_wr, io_ram_addr}, {1'b1, 1'b0, io_video_addr});
        vid_q.push_back(ref_rd(int'(io_video_addr)));
      end else if (pend_q.size() > 0 && cyc > pend_q[0].req_cyc) begin
        // first video-free cycle after the request: the CPU access lands here
        x = pend_q.pop_front();
        chk("cpu_ram_op", {io_ram_rd, io_ram_wr, io_ram_addr}, {~x.wr, x.wr, x.addr});
        waited = cyc - x.req_cyc - 1;
        if (waited > 255) waited = 255;
        if (waited > ref_maxwait) ref_maxwait = waited;
        if (x.wr) begin
          chk("cpu_ram_din", {io_ram_mask, io_ram_din}, {x.mask, x.din});
          e = ref_rd(int'(x.addr));
          if (x.mask[0]) e[7:0]  = x.din[7:0];
          if (x.mask[1]) e[15:8] = x.din[15:8];
          ref_mem[int'(x.addr)] = e;
          a.cyc = cyc + 1; a.rd = 1'b0; a.dout = '0;
        end else begin
          a.cyc = cyc + 2; a.rd = 1'b1; a.dout = ref_rd(int'(x.addr));
        end
        ack_q.push_back(a);
      end else if (io_ram_rd || io_ram_wr) begin
        fail_now("spurious_ram_access");
      end
    end
  end

  // ---------------- video stimulus ----------------
  // 0: idle, 1: random, 2: every other cycle, 3: held high
  int vmode = 0;
  always begin
    @(posedge clock);
    #1;
    case (vmode)
      1:       io_video_rd = 1'($urandom_range(0, 1));
      2:       io_video_rd = ~io_video_rd;
      3:       io_video_rd = 1'b1;
      default: io_video_rd = 1'b0;
    endcase
    io_video_addr = ($urandom_range(0, 3) == 0) ? 15'h0123 : 15'($urandom_range(0, 15));
  end

  // ---------------- CPU driver ----------------
  int xact_no = 0;

  task automatic cpu_xact(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din, input logic [1:0] mask, input int hold);
    xact_t x;
    int    n;
    bit    got;
    int    t0;
    @(posedge clock);
    #1;
    io_cpu_rd = rd; io_cpu_wr = wr;
    io_cpu_addr = addr; io_cpu_din = din; io_cpu_mask = mask;
    x.wr = wr; x.addr = addr; x.din = din; x.mask = mask; x.req_cyc = cyc;
    t0 = cyc;
    pend_q.push_back(x);
    n = 0; got = 1'b0;
    while (n < 2000 && !got) begin
      @(negedge clock);
      n++;
      // after the latch edge, scramble the inputs: they must be ignored
      if (n == 2) begin
        io_cpu_addr = 15'($urandom); io_cpu_din = 16'($urandom); io_cpu_mask = 2'($urandom);
      end
      if (io_cpu_ack) got = 1'b1;
    end
    if (!got) fail_now("ack_timeout");
    repeat (hold) begin
      @(negedge clock);
      chk("ack_held", io_cpu_ack, 1);
    end
    @(posedge clock);
    #1;
    io_cpu_rd = 1'b0; io_cpu_wr = 1'b0;
    @(negedge clock);
    chk("ack_until_drop_seen", io_cpu_ack, 1);
    @(negedge clock);
    chk("ack_fall", io_cpu_ack, 0);
    chk("max_wait", io_maxWait, ref_maxwait);
    xact_no++;
    $display("xact %0d: %s addr=%h din=%h mask=%b hold=%0d latency=%0d dout=%h maxWait=%0d",
             xact_no, wr ? "WR" : "RD", addr, din, mask, hold, cyc - t0, io_cpu_dout, io_maxWait);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    io_video_rd = 1'b0; io_video_addr = '0;
    io_cpu_rd = 1'b0; io_cpu_wr = 1'b0; io_cpu_addr = '0; io_cpu_din = '0; io_cpu_mask = '0;
    repeat (3) begin
      @(negedge clock);
      chk("reset_ram_wr", io_ram_wr, 0);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_ack", io_cpu_ack, 0);
    chk("reset_cpu_dout", io_cpu_dout, 0);
    chk("reset_video_valid", io_video_valid, 0);
    chk("reset_max_wait", io_maxWait, 0);

    // write with idle video
    cpu_xact(1'b0, 1'b1, 15'h0123, 16'hBEEF, 2'b11, 0);
    chk("ram_holds_beef", mem_rd(32'h123), 16'hBEEF);

    // read with video every other cycle
    @(negedge clock) vmode = 2;
    cpu_xact(1'b1, 1'b0, 15'h0123, 16'h0000, 2'b11, 0);
    chk("cpu_dout_beef", io_cpu_dout, 16'hBEEF);
    chk("max_wait_le1", 32'(io_maxWait <= 1), 1);

    // video held for 300 cycles during a pending write
    @(negedge clock) vmode = 3;
    fork
      cpu_xact(1'b0, 1'b1, 15'h0005, 16'h1234, 2'b11, 0);
      begin
        repeat (300) @(negedge clock);
        vmode = 0;
      end
    join
    chk("max_wait_saturated", io_maxWait, 255);
    chk("long_write_landed", mem_rd(5), 16'h1234);

    // read+write together, lower byte only
    cpu_xact(1'b1, 1'b1, 15'h0123, 16'h12AB, 2'b01, 0);
    chk("lower_byte_only", mem_rd(32'h123), 16'hBEAB);

    // hold the request 10 cycles after ack, then a fresh request
    cpu_xact(1'b0, 1'b1, 15'h0007, 16'hCAFE, 2'b10, 10);
    cpu_xact(1'b1, 1'b0, 15'h0007, 16'h0000, 2'b11, 0);
    chk("upper_byte_only", io_cpu_dout, 16'hCA00);

    // reset during PEND of a write
    @(negedge clock) vmode = 3;
    @(posedge clock); #1;
    io_cpu_wr = 1'b1; io_cpu_addr = 15'h0123; io_cpu_din = 16'h5555; io_cpu_mask = 2'b11;
    repeat (5) @(negedge clock);
    vmode = 0;
    @(posedge clock); #1;
    reset = 1'b1; io_cpu_wr = 1'b0;
    @(negedge clock);
    chk("no_write_in_reset", io_ram_wr, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ack", io_cpu_ack, 0);
    chk("post_reset_max_wait", io_maxWait, 0);
    chk("post_reset_cpu_dout", io_cpu_dout, 0);
    chk("write_discarded", mem_rd(32'h123), 16'hBEAB);
    cpu_xact(1'b1, 1'b0, 15'h0123, 16'h0000, 2'b11, 0);

    // randomized traffic
    repeat (40) begin
      int op;
      @(negedge clock) vmode = $urandom_range(0, 2);
      op = $urandom_range(1, 3);
      cpu_xact(op[1], op[0], 15'($urandom_range(0, 15)), 16'($urandom), 2'($urandom),
               $urandom_range(0, 3));
    end

    @(negedge clock) vmode = 0;
    repeat (4) @(negedge clock);
    chk("video_queue_drained", vid_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
